// File: rtl/cent_pkg.sv
// cent_pkg: shared trackball constants, quadrature states and packed-format positions.
package cent_pkg;
  localparam int TRAK_CNT_W = 4;
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam int TRAK_H_LSB = 0;
  localparam int TRAK_V_LSB = 4;
  localparam int DIR_H_BIT = 0;
  localparam int DIR_V_BIT = 1;
  function automatic logic [1:0] qs_next(input logic [1:0] s);
    return s == QS_00 ? QS_01 : s == QS_01 ? QS_11 : s == QS_11 ? QS_10 : QS_00;
  endfunction
endpackage

// File: rtl/quad_axis.sv
// quad_axis: one encoder axis (sync, optional TRAKBALL_FILTER_EN filter, decoder, counter).
module quad_axis
  import cent_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W = TRAK_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             flip,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             err
);
  localparam int WARM_W = $clog2(FILTER_LEN + 3);
`ifdef TRAKBALL_FILTER_EN
  localparam logic [WARM_W-1:0] WARM = WARM_W'(FILTER_LEN + 2);
`else
  localparam logic [WARM_W-1:0] WARM = WARM_W'(2);
`endif
  logic [1:0] s1, s2, cur, prev;
  logic [WARM_W-1:0] warm;
  logic valid, fwd, ill, up;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
`ifdef TRAKBALL_FILTER_EN
  for (genvar i = 0; i < 2; i++) begin : g_flt
    logic [3:0] stab;
    logic lvl;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        lvl  <= 1'b0;
        stab <= '0;
      end else if (s2[i] == lvl) stab <= '0;
      else if (stab == 4'(FILTER_LEN - 1)) begin
        lvl  <= s2[i];
        stab <= '0;
      end else stab <= stab + 4'd1;
    assign cur[i] = lvl;
  end
`else
  assign cur = s2;
`endif
  assign fwd = cur == qs_next(prev);
  assign ill = cur == ~prev;
  assign up  = fwd ^ flip;
  // valid waits until the pipeline holds a real pin sample, so levels present at reset never count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      warm  <= '0;
      valid <= 1'b0;
      prev  <= QS_00;
      count <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (warm != WARM) warm <= warm + 1'b1;
      if (!valid) begin
        if (warm == WARM) begin
          prev  <= cur;
          valid <= 1'b1;
        end
      end else if (cur != prev) begin
        prev <= cur;
        if (ill) err <= 1'b1;
        else begin
          count <= up ? count + 1'b1 : count - 1'b1;
          dir   <= !up;
        end
      end
    end
endmodule

// File: rtl/trakball_quad_rx.sv
// trakball_quad_rx: Centipede trackball quadrature receiver, packs both axes for the core.
// Define TRAKBALL_FILTER_EN to add a FILTER_LEN-sample glitch filter on every phase.
module trakball_quad_rx
  import cent_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W = TRAK_CNT_W
) (
  input  logic       clk12m,
  input  logic       reset_n,
  input  logic       h_a,
  input  logic       h_b,
  input  logic       v_a,
  input  logic       v_b,
  input  logic       flip,
  output logic [7:0] trakball_o,
  output logic [1:0] dir_o,
  output logic       err_o
);
  logic [CNT_W-1:0] h_count, v_count;
  logic h_dir, v_dir, h_err, v_err;
  quad_axis #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_h (
    .clk(clk12m), .rst_n(reset_n), .a(h_a), .b(h_b), .flip(flip),
    .count(h_count), .dir(h_dir), .err(h_err)
  );
  quad_axis #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W)) u_v (
    .clk(clk12m), .rst_n(reset_n), .a(v_a), .b(v_b), .flip(flip),
    .count(v_count), .dir(v_dir), .err(v_err)
  );
  assign trakball_o[TRAK_H_LSB +: TRAK_CNT_W] = h_count[TRAK_CNT_W-1:0];
  assign trakball_o[TRAK_V_LSB +: TRAK_CNT_W] = v_count[TRAK_CNT_W-1:0];
  assign dir_o[DIR_H_BIT] = h_dir;
  assign dir_o[DIR_V_BIT] = v_dir;
  assign err_o = h_err | v_err;
endmodule
